// File: rtl/min_max_pkg.sv
// Shared constants for the min/max finder: one-hot state codes and default geometry.
package min_max_pkg;

  localparam logic [3:0] MMF_INI  = 4'b0001;
  localparam logic [3:0] MMF_LOAD = 4'b0010;
  localparam logic [3:0] MMF_CMP  = 4'b0100;
  localparam logic [3:0] MMF_DONE = 4'b1000;

  localparam int MMF_DEF_WIDTH = 8;
  localparam int MMF_DEF_DEPTH = 16;

endpackage

// File: rtl/mmf_cmp_unit.sv
// Combinational element-vs-running-extreme compare; ties report true on both sides.
// Zero latency, no handshake.
module mmf_cmp_unit #(
  parameter int WIDTH  = 8,
  parameter int SIGNED = 0
) (
  input  logic [WIDTH-1:0] elem,
  input  logic [WIDTH-1:0] max_val,
  input  logic [WIDTH-1:0] min_val,
  output logic             ge_max,
  output logic             le_min
);

  generate
    if (SIGNED != 0) begin : g_signed
      assign ge_max = $signed(elem) >= $signed(max_val);
      assign le_min = $signed(elem) <= $signed(min_val);
    end else begin : g_unsigned
      assign ge_max = elem >= max_val;
      assign le_min = elem <= min_val;
    end
  endgenerate

endmodule

// File: rtl/min_max_finder_param.sv
// Scans M[0..Last] for max/min (optional MaxIdx/MinIdx under MMF_INDEX_EN); result held until Ack.
// Start-to-DONE latency is Last+2 clocks; Start/WrEn only honoured in INI, Ack only in DONE.
module min_max_finder_param
  import min_max_pkg::*;
#(
  parameter  int WIDTH  = MMF_DEF_WIDTH,
  parameter  int DEPTH  = MMF_DEF_DEPTH,
  parameter  int SIGNED = 0,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Ack,
  input  logic [AW-1:0]    LastIdx,
  input  logic             WrEn,
  input  logic [AW-1:0]    WrAddr,
  input  logic [WIDTH-1:0] WrData,
  output logic [WIDTH-1:0] Max,
  output logic [WIDTH-1:0] Min,
`ifdef MMF_INDEX_EN
  output logic [AW-1:0]    MaxIdx,
  output logic [AW-1:0]    MinIdx,
`endif
  output logic             Qi,
  output logic             Ql,
  output logic             Qc,
  output logic             Qd
);

  localparam logic [AW:0]   DEPTH_W  = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST_MAX = AW'(DEPTH - 1);

  logic [3:0]       state_q, state_d;
  logic [WIDTH-1:0] max_q, max_d, min_q, min_d;
  logic [AW-1:0]    i_q, i_d, last_q, last_d;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] elem;
  logic             ge_max, le_min;
`ifdef MMF_INDEX_EN
  logic [AW-1:0]    maxidx_q, maxidx_d, minidx_q, minidx_d;
`endif

  assign elem = mem[i_q];

  mmf_cmp_unit #(.WIDTH(WIDTH), .SIGNED(SIGNED)) u_cmp (
    .elem    (elem),
    .max_val (max_q),
    .min_val (min_q),
    .ge_max  (ge_max),
    .le_min  (le_min)
  );

  always_comb begin
    state_d = state_q;
    max_d   = max_q;
    min_d   = min_q;
    i_d     = i_q;
    last_d  = last_q;
`ifdef MMF_INDEX_EN
    maxidx_d = maxidx_q;
    minidx_d = minidx_q;
`endif
    case (state_q)
      MMF_INI: begin
        i_d    = '0;
        last_d = (LastIdx > LAST_MAX) ? LAST_MAX : LastIdx;
        if (Start) state_d = MMF_LOAD;
      end
      MMF_LOAD: begin
        max_d   = mem[0];
        min_d   = mem[0];
        i_d     = AW'(1);
`ifdef MMF_INDEX_EN
        maxidx_d = '0;
        minidx_d = '0;
`endif
        state_d = (last_q == '0) ? MMF_DONE : MMF_CMP;
      end
      MMF_CMP: begin
        if (ge_max) begin
          max_d = elem;
`ifdef MMF_INDEX_EN
          maxidx_d = i_q;
`endif
        end
        if (le_min) begin
          min_d = elem;
`ifdef MMF_INDEX_EN
          minidx_d = i_q;
`endif
        end
        if (i_q == last_q) state_d = MMF_DONE;
        else               i_d     = i_q + AW'(1);
      end
      MMF_DONE: begin
        if (Ack) state_d = MMF_INI;
      end
      default: state_d = MMF_INI;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= MMF_INI;
      max_q   <= '0;
      min_q   <= '0;
      i_q     <= '0;
      last_q  <= '0;
`ifdef MMF_INDEX_EN
      maxidx_q <= '0;
      minidx_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      max_q   <= max_d;
      min_q   <= min_d;
      i_q     <= i_d;
      last_q  <= last_d;
`ifdef MMF_INDEX_EN
      maxidx_q <= maxidx_d;
      minidx_q <= minidx_d;
`endif
    end
  end

  // Array is plain storage with no reset; out-of-range addresses are dropped.
  always_ff @(posedge Clk) begin
    if (state_q == MMF_INI && WrEn && ({1'b0, WrAddr} < DEPTH_W))
      mem[WrAddr] <= WrData;
  end

  assign Max = max_q;
  assign Min = min_q;
  assign Qi  = state_q[0];
  assign Ql  = state_q[1];
  assign Qc  = state_q[2];
  assign Qd  = state_q[3];
`ifdef MMF_INDEX_EN
  assign MaxIdx = maxidx_q;
  assign MinIdx = minidx_q;
`endif

endmodule

// File: tb/tb_min_max_finder_param.sv
// Bench: instance 0 default unsigned, instance 1 signed, instance 2 DEPTH=10; scoreboard of expected scan results.
module tb_min_max_finder_param;

  logic                 Clk, Reset;
  logic [2:0]           start, ack, wr_en;
  logic [2:0][3:0]      last_idx, wr_addr;
  logic [2:0][7:0]      wr_data;
  wire  [2:0][7:0]      max_o, min_o;
  wire  [2:0]           qi, ql, qc, qd;
`ifdef MMF_INDEX_EN
  wire  [2:0][3:0]      max_i, min_i;
`endif

  typedef struct {
    logic [7:0] mx;
    logic [7:0] mn;
    int         mxi;
    int         mni;
    int         lat;
  } exp_t;

  exp_t       sb[$];
  exp_t       cur;
  logic [7:0] model [3][16];
  int         compared = 0;
  int         mismatched = 0;
  int         cyc = 0;
  int         st_cyc [3];

  min_max_finder_param u_dut0 (
    .Clk(Clk), .Reset(Reset), .Start(start[0]), .Ack(ack[0]), .LastIdx(last_idx[0]),
    .WrEn(wr_en[0]), .WrAddr(wr_addr[0]), .WrData(wr_data[0]), .Max(max_o[0]), .Min(min_o[0]),
`ifdef MMF_INDEX_EN
    .MaxIdx(max_i[0]), .MinIdx(min_i[0]),
`endif
    .Qi(qi[0]), .Ql(ql[0]), .Qc(qc[0]), .Qd(qd[0]));

  min_max_finder_param #(.SIGNED(1)) u_dut1 (
    .Clk(Clk), .Reset(Reset), .Start(start[1]), .Ack(ack[1]), .LastIdx(last_idx[1]),
    .WrEn(wr_en[1]), .WrAddr(wr_addr[1]), .WrData(wr_data[1]), .Max(max_o[1]), .Min(min_o[1]),
`ifdef MMF_INDEX_EN
    .MaxIdx(max_i[1]), .MinIdx(min_i[1]),
`endif
    .Qi(qi[1]), .Ql(ql[1]), .Qc(qc[1]), .Qd(qd[1]));

  min_max_finder_param #(.DEPTH(10)) u_dut2 (
    .Clk(Clk), .Reset(Reset), .Start(start[2]), .Ack(ack[2]), .LastIdx(last_idx[2]),
    .WrEn(wr_en[2]), .WrAddr(wr_addr[2]), .WrData(wr_data[2]), .Max(max_o[2]), .Min(min_o[2]),
`ifdef MMF_INDEX_EN
    .MaxIdx(max_i[2]), .MinIdx(min_i[2]),
`endif
    .Qi(qi[2]), .Ql(ql[2]), .Qc(qc[2]), .Qd(qd[2]));

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  function automatic int depth_of(input int k);
    return (k == 2) ? 10 : 16;
  endfunction

  // Reference scan: clamp the length, ties move the extreme (last occurrence wins).
  function automatic exp_t ref_scan(input int k, input int last);
    exp_t e;
    int   l;
    l = (last > depth_of(k) - 1) ? depth_of(k) - 1 : last;
    e.mx = model[k][0];
    e.mn = model[k][0];
    e.mxi = 0;
    e.mni = 0;
    for (int i = 1; i <= l; i++) begin
      logic [7:0] v;
      logic       ge, le;
      v = model[k][i];
      if (k == 1) begin
        ge = $signed(v) >= $signed(e.mx);
        le = $signed(v) <= $signed(e.mn);
      end else begin
        ge = v >= e.mx;
        le = v <= e.mn;
      end
      if (ge) begin e.mx = v; e.mxi = i; end
      if (le) begin e.mn = v; e.mni = i; end
    end
    e.lat = l + 2;
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input int k, input int a, input logic [7:0] d);
    wr_en[k]   = 1'b1;
    wr_addr[k] = 4'(a);
    wr_data[k] = d;
    if (a < depth_of(k)) model[k][a] = d;
    @(negedge Clk);
    wr_en[k] = 1'b0;
  endtask

  task automatic start_scan(input int k, input int last);
    sb.push_back(ref_scan(k, last));
    last_idx[k] = 4'(last);
    start[k]    = 1'b1;
    st_cyc[k]   = cyc;
    @(negedge Clk);
    start[k] = 1'b0;
  endtask

  task automatic wait_done(input int k);
    while (qd[k] !== 1'b1 && (cyc - st_cyc[k]) < 64) @(negedge Clk);
    check("done_seen", 32'(qd[k]), 32'd1);
    cur = sb.pop_front();
    check("latency", cyc - st_cyc[k], cur.lat);
    check("max", 32'(max_o[k]), 32'(cur.mx));
    check("min", 32'(min_o[k]), 32'(cur.mn));
`ifdef MMF_INDEX_EN
    check("max_idx", 32'(max_i[k]), cur.mxi);
    check("min_idx", 32'(min_i[k]), cur.mni);
`endif
  endtask

  task automatic hold_check(input int k, input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge Clk);
      check("hold_qd", 32'(qd[k]), 32'd1);
      check("hold_max", 32'(max_o[k]), 32'(cur.mx));
      check("hold_min", 32'(min_o[k]), 32'(cur.mn));
    end
  endtask

  task automatic do_ack(input int k);
    ack[k] = 1'b1;
    @(negedge Clk);
    ack[k] = 1'b0;
    check("ack_to_ini", 32'(qi[k]), 32'd1);
    check("ack_qd_low", 32'(qd[k]), 32'd0);
  endtask

  initial begin
    Reset = 1'b1;
    start = '0; ack = '0; wr_en = '0;
    last_idx = '0; wr_addr = '0; wr_data = '0;
    repeat (2) @(negedge Clk);
    for (int k = 0; k < 3; k++) begin
      check("rst_state", {28'd0, qd[k], qc[k], ql[k], qi[k]}, 32'h1);
      check("rst_max", 32'(max_o[k]), 32'd0);
      check("rst_min", 32'(min_o[k]), 32'd0);
    end
    Reset = 1'b0;
    @(negedge Clk);

    // 1: full 16-entry unsigned scan
    for (int i = 0; i < 16; i++)
      wr(0, i, (i == 7) ? 8'hFF : (i == 12) ? 8'h00 : 8'(8'h10 + i * 11));
    start_scan(0, 15);
    wait_done(0);
    check("t1_max_const", 32'(max_o[0]), 32'hFF);
    check("t1_min_const", 32'(min_o[0]), 32'h00);
    hold_check(0, 3);
    do_ack(0);

    // 2: single-element scan; write lands in the Start cycle
    wr_en[0] = 1'b1; wr_addr[0] = 4'd0; wr_data[0] = 8'h5A; model[0][0] = 8'h5A;
    start_scan(0, 0);
    wr_en[0] = 1'b0;
    wait_done(0);
    check("t2_max_const", 32'(max_o[0]), 32'h5A);
    do_ack(0);

    // 3: signed vs unsigned on the same data
    wr(1, 0, 8'h7F); wr(1, 1, 8'h80); wr(1, 2, 8'h01); wr(1, 3, 8'hFF);
    wr(0, 0, 8'h7F); wr(0, 1, 8'h80); wr(0, 2, 8'h01); wr(0, 3, 8'hFF);
    start_scan(1, 3);
    wait_done(1);
    check("t3_smax", 32'(max_o[1]), 32'h7F);
    check("t3_smin", 32'(min_o[1]), 32'h80);
    do_ack(1);
    start_scan(0, 3);
    wait_done(0);
    check("t3_umax", 32'(max_o[0]), 32'hFF);
    check("t3_umin", 32'(min_o[0]), 32'h01);
    do_ack(0);

    // 4: ties, last occurrence wins
    wr(0, 0, 8'd3); wr(0, 1, 8'd9); wr(0, 2, 8'd1); wr(0, 3, 8'd9); wr(0, 4, 8'd1);
    start_scan(0, 4);
    wait_done(0);
    do_ack(0);

    // 5: reset at the third CMP cycle, then writes outside INI
    start_scan(0, 15);
    repeat (3) @(negedge Clk);
    check("t5_in_cmp", 32'(qc[0]), 32'd1);
    Reset = 1'b1;
    #1;
    check("t5_rst_qi", 32'(qi[0]), 32'd1);
    check("t5_rst_max", 32'(max_o[0]), 32'd0);
    check("t5_rst_min", 32'(min_o[0]), 32'd0);
    cur = sb.pop_front();
    @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    start_scan(0, 4);
    wr_en[0] = 1'b1; wr_addr[0] = 4'd2; wr_data[0] = 8'h77;
    repeat (2) @(negedge Clk);
    wr_en[0] = 1'b0;
    wait_done(0);
    wr_en[0] = 1'b1; wr_addr[0] = 4'd4; wr_data[0] = 8'h00;
    @(negedge Clk);
    wr_en[0] = 1'b0;
    do_ack(0);
    start_scan(0, 4);
    wait_done(0);
    check("t5_rescan_max", 32'(max_o[0]), 32'd9);
    check("t5_rescan_min", 32'(min_o[0]), 32'd1);
    do_ack(0);

    // 6: DEPTH=10 clamps LastIdx, drops out-of-range write, ignores Start in DONE
    for (int i = 0; i < 10; i++)
      wr(2, i, (i == 4) ? 8'hE0 : (i == 9) ? 8'h05 : 8'(8'h30 + i * 3));
    wr(2, 12, 8'h01);
    start_scan(2, 15);
    wait_done(2);
    check("t6_lat_const", cyc - st_cyc[2], 32'd11);
    check("t6_min_const", 32'(min_o[2]), 32'h05);
    start[2] = 1'b1;
    @(negedge Clk);
    start[2] = 1'b0;
    check("t6_start_ignored_qd", 32'(qd[2]), 32'd1);
    check("t6_start_ignored_ql", 32'(ql[2]), 32'd0);
    hold_check(2, 2);
    do_ack(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/min_max_finder_param.md
Name: min_max_finder_param

Overview:
Parametrised successor to the 16 x 8-bit min/max finder.
- Holds an internal array of DEPTH words of WIDTH bits, loaded through a write port.
- On Start, scans elements 0..LastIdx, one element per clock, against both the running Max and the running Min.
- Reports Max and Min, then holds them until the consumer acknowledges.
- Supports unsigned or signed compare, and a runtime scan length.

Parameters:
WIDTH, 8, element width in bits (>=2)
DEPTH, 16, number of array entries (>=2, need not be a power of 2)
SIGNED, 0, 0 = unsigned compare, 1 = two's-complement compare
AW, $clog2(DEPTH), index width; localparam, not overridable

Ports:
Clk  in  1  clock, rising edge
Reset  in  1  reset; asynchronous, active-high
Start  in  1  begin scan; honoured only in INI
Ack  in  1  consumer acknowledge; honoured only in DONE
LastIdx  in  AW  index of last element to scan; sampled in INI
WrEn  in  1  array write enable; honoured only in INI
WrAddr  in  AW  array write address
WrData  in  WIDTH  array write data
Max  out  WIDTH  largest element of scanned range
Min  out  WIDTH  smallest element of scanned range
Qi  out  1  one-hot state bit: INI
Ql  out  1  one-hot state bit: LOAD
Qc  out  1  one-hot state bit: CMP
Qd  out  1  one-hot state bit: DONE

Behaviour:
- Reset (async, any state): state=INI, Max=0, Min=0, I=0, Last=0. Array contents are not reset.
- State encoding: one-hot {Qd,Qc,Ql,Qi}.
  - INI=0001
  - LOAD=0010
  - CMP=0100
  - DONE=1000
- INI:
  - If WrEn, M[WrAddr] <= WrData. A WrAddr >= DEPTH is ignored.
  - Every cycle: I <= 0 and Last <= min(LastIdx, DEPTH-1).
  - If Start, go to LOAD. A write in the same cycle as Start is included in the scan.
- LOAD: Max <= M[0], Min <= M[0], I <= 1.
  - If Last==0, go to DONE.
  - Otherwise go to CMP.
- CMP, one element per cycle:
  - Max: if M[I] >= Max (tie updates), Max <= M[I].
  - Min: if M[I] <= Min (tie updates), Min <= M[I].
  - Both updates may occur in the same cycle.
  - If I==Last, go to DONE; otherwise I <= I+1 and stay in CMP.
- DONE: Max and Min stable.
  - If Ack, go to INI. Otherwise hold.
  - Start is ignored.
- Compare is signed or unsigned per SIGNED.
- Latency from the Start cycle to the first DONE cycle is Last+2 clocks (Last=0 gives 2).
- WrEn outside INI: no effect on the array. Start or Ack outside their own states: no effect.
- Reset mid-scan: immediate return to INI. Max/Min are cleared; no partial result is retained.

Optional Feature:
Macro: MMF_INDEX_EN.
- When defined, adds outputs MaxIdx[AW] and MinIdx[AW], both reset to 0.
  - LOAD sets both to 0.
  - In CMP, each is set to I whenever the corresponding Max/Min update fires. Tie rule: the last occurrence wins.
- When undefined, the ports and registers are absent and behaviour is otherwise identical.

Decomposition:
- Shared package min_max_pkg: state localparams (MMF_INI, MMF_LOAD, MMF_CMP, MMF_DONE, 4-bit one-hot) and a default WIDTH/DEPTH constant pair.
- One natural sub-module: mmf_cmp_unit.
  - Combinational; parameters WIDTH and SIGNED.
  - Produces ge_max and le_min from the element and the running Max/Min.
- The FSM, counter and array stay in the top module.

Test Plan:
1. Defaults: write 16 unsigned values with 8'hFF at index 7 and 8'h00 at index 12; LastIdx=15; Start → Max=FF, Min=00; Qd first asserts 17 clocks after Start; outputs hold until Ack.
2. LastIdx=0 with M[0]=8'h5A → DONE after 2 clocks, Max=Min=5A; Ack → Qi next cycle.
3. SIGNED=1, values {8'h7F, 8'h80, 8'h01, 8'hFF}, LastIdx=3 → Max=7F, Min=80; repeat with SIGNED=0 → Max=FF, Min=01.
4. MMF_INDEX_EN with ties: values {3,9,1,9,1}, LastIdx=4 → Max=9, MaxIdx=3; Min=1, MinIdx=4.
5. Assert Reset at the third CMP cycle → Qi=1 and Max=Min=0 immediately. WrEn during CMP and DONE leaves the array unchanged; verify by rescan.
6. DEPTH=10, LastIdx=15 → clamped, scan ends at index 9. WrAddr=12 is ignored. Start asserted during DONE is ignored.
